// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed scan driver for a common-segment 7-seg bank.
// Each digit gets a dark gap of BLANK_CYCLES, then it is lit for DWELL_CYCLES.
// During the dark gap the shared segment bus is forced to all-off.
// The segment pattern is latched when the digit lights, so input changes
// during the dwell cannot tear the displayed digit.
module seg_scan_mux #(
  parameter int NUM_DIGITS    = 8,
  parameter int DWELL_CYCLES  = 1000,
  parameter int BLANK_CYCLES  = 16,
  parameter bit AN_ACTIVE_LOW = 1'b1,
  localparam int DIG_W   = $clog2(NUM_DIGITS),
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES,
  localparam int CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [7:0]            segs_i [NUM_DIGITS],
  output logic [7:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [DIG_W-1:0]      digit_o,
  output logic                  frame_done_o
);

  localparam logic [7:0]            SEG_NONE   = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [DIG_W-1:0]      DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Digit-enable pattern lighting digit d, in the configured polarity.
  function automatic logic [NUM_DIGITS-1:0] an_on(input logic [DIG_W-1:0] d);
    logic [NUM_DIGITS-1:0] oh;
    oh    = '0;
    oh[d] = 1'b1;
    return AN_ACTIVE_LOW ? ~oh : oh;
  endfunction

  // Scan FSM: alternate dark gap and dwell per digit, all outputs registered.
  // NOTE: every register here uses <= so all next-state terms read the values
  // from before the edge; a blocking = would let cnt/digit_o updates leak into
  // the same edge's decisions and break the cycle counts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_BLANK;
      cnt          <= '0;
      digit_o      <= '0;
      seg_o        <= SEG_NONE;
      an_o         <= AN_OFF;
      frame_done_o <= 1'b0;
    end else if (!en_i) begin
      // Disabled: park in the dark gap before digit 0, abort any frame.
      state        <= ST_BLANK;
      cnt          <= '0;
      digit_o      <= '0;
      seg_o        <= SEG_NONE;
      an_o         <= AN_OFF;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= ST_SHOW;
            seg_o <= segs_i[digit_o];
            an_o  <= an_on(digit_o);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt == DWELL_LAST) begin
            cnt   <= '0;
            state <= ST_BLANK;
            seg_o <= SEG_NONE;
            an_o  <= AN_OFF;
            if (digit_o == DIG_LAST) begin
              digit_o      <= '0;
              frame_done_o <= 1'b1;
            end else begin
              digit_o <= digit_o + DIG_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_BLANK;
          cnt   <= '0;
          seg_o <= SEG_NONE;
          an_o  <= AN_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: randomized bench for seg_scan_mux with a frame-arithmetic
// reference model (position inside the frame decides digit and dark/lit).
module tb_seg_scan_mux;

  localparam int ND    = 4;
  localparam int DW    = 3;
  localparam int BC    = 2;
  localparam int SLOT  = BC + DW;
  localparam int FRAME = ND * SLOT;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [7:0]  segs [ND];
  logic [7:0]  seg_o, seg2_o;
  logic [3:0]  an_o, an2_o;
  logic [1:0]  digit_o, digit2_o;
  logic        frame_done_o, fd2_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  seg_scan_mux #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BC), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .segs_i(segs),
    .seg_o(seg_o), .an_o(an_o), .digit_o(digit_o), .frame_done_o(frame_done_o)
  );

  seg_scan_mux #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BC), .AN_ACTIVE_LOW(1'b0)) dut_hi (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .segs_i(segs),
    .seg_o(seg2_o), .an_o(an2_o), .digit_o(digit2_o), .frame_done_o(fd2_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mt = enabled edges since scan (re)start; lat = pattern
  // captured at the edge on which the current digit lit.
  int         mt;
  logic [7:0] lat;

  always @(posedge clk_i or posedge rst_i) begin
    int n;
    if (rst_i) begin
      mt  <= 0;
      lat <= 8'hFF;
    end else begin
      n = en_i ? mt + 1 : 0;
      mt <= n;
      if ((n % FRAME) % SLOT == BC) lat <= segs[(n % FRAME) / SLOT];
    end
  end

  function automatic logic m_lit();
    return ((mt % FRAME) % SLOT) >= BC;
  endfunction

  function automatic logic [1:0] m_digit();
    return 2'((mt % FRAME) / SLOT);
  endfunction

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk_i) begin
    logic [3:0] oh;
    oh = m_lit() ? (4'b0001 << m_digit()) : 4'b0000;
    check("seg_o",        {24'd0, seg_o},   {24'd0, m_lit() ? lat : 8'hFF});
    check("an_o",         {28'd0, an_o},    {28'd0, ~oh});
    check("digit_o",      {30'd0, digit_o}, {30'd0, m_digit()});
    check("frame_done_o", {31'd0, frame_done_o},
          {31'd0, (mt != 0) && (mt % FRAME == 0)});
    check("an_onehot",    $countones(~an_o) <= 1, 1);
    check("an_hi",        {28'd0, an2_o},   {28'd0, oh});
    check("seg_hi",       {24'd0, seg2_o},  {24'd0, seg_o});
  end

  // Hand-computed first frame after reset release (t = cycles since release).
  logic [3:0] exp_an  [21] = '{4'hF,4'hF,4'hE,4'hE,4'hE,4'hF,4'hF,4'hD,4'hD,4'hD,4'hF,
                               4'hF,4'hB,4'hB,4'hB,4'hF,4'hF,4'h7,4'h7,4'h7,4'hF};
  logic [7:0] exp_seg [21] = '{8'hFF,8'hFF,8'h03,8'h03,8'h03,8'hFF,8'hFF,8'h9F,8'h9F,8'h9F,8'hFF,
                               8'hFF,8'h25,8'h25,8'h25,8'hFF,8'hFF,8'h0D,8'h0D,8'h0D,8'hFF};

  initial begin
    int pulses;
    int last_pulse;
    rst_i = 1'b1;
    en_i  = 1'b1;
    segs  = '{8'h03, 8'h9F, 8'h25, 8'h0D};
    repeat (3) @(negedge clk_i);
    @(posedge clk_i); #2 rst_i = 1'b0;
    repeat (4) @(negedge clk_i);   // now in SHOW of digit 0

    // Asynchronous reset between edges darkens immediately.
    #1 rst_i = 1'b1;
    #1;
    check("rst_seg",   {24'd0, seg_o},        32'hFF);
    check("rst_an",    {28'd0, an_o},         32'hF);
    check("rst_an_hi", {28'd0, an2_o},        32'h0);
    check("rst_digit", {30'd0, digit_o},      32'd0);
    check("rst_fd",    {31'd0, frame_done_o}, 32'd0);
    @(posedge clk_i); #2 rst_i = 1'b0;

    // Three frames with literal pins; segs[1] changes mid-dwell of digit 1.
    for (int t = 0; t < 60; t++) begin
      @(negedge clk_i);
      if (t <= 20) begin
        check("lit_an",  {28'd0, an_o},  {28'd0, exp_an[t]});
        check("lit_seg", {24'd0, seg_o}, {24'd0, exp_seg[t]});
        check("lit_fd",  {31'd0, frame_done_o}, {31'd0, t == 20});
      end
      if (t == 2)  check("lit_an_hi", {28'd0, an2_o}, 32'h1);
      if (t == 27) begin
        check("new_seg1", {24'd0, seg_o}, 32'hFF);
        check("new_an1",  {28'd0, an_o},  32'hD);
      end
      if (t == 40) check("lit_fd40", {31'd0, frame_done_o}, 32'd1);
      if (t == 8)  segs[1] = 8'hFF;
    end

    // Drop enable during digit 2's dwell (t = 72).
    repeat (13) @(negedge clk_i);
    check("pre_drop_an", {28'd0, an_o}, 32'hB);
    en_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("dis_an",    {28'd0, an_o},    32'hF);
      check("dis_seg",   {24'd0, seg_o},   32'hFF);
      check("dis_digit", {30'd0, digit_o}, 32'd0);
      check("dis_fd",    {31'd0, frame_done_o}, 32'd0);
    end
    segs[1] = 8'h9F;
    en_i = 1'b1;
    @(negedge clk_i);
    check("re_dark_an", {28'd0, an_o}, 32'hF);
    @(negedge clk_i);
    check("re_lit_an",  {28'd0, an_o},  32'hE);
    check("re_lit_seg", {24'd0, seg_o}, 32'h03);

    // Count frame pulses over three full frames: t = 20, 40, 60.
    pulses = 0;
    last_pulse = 0;
    for (int t = 3; t <= 65; t++) begin
      @(negedge clk_i);
      if (frame_done_o) begin
        if (pulses > 0) check("pulse_gap", t - last_pulse, FRAME);
        pulses++;
        last_pulse = t;
      end
    end
    check("pulse_count", pulses, 3);

    // Randomized phase: pattern churn and enable drops.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_i);
      if ($urandom_range(0, 3) == 0) segs[$urandom_range(0, ND - 1)] = 8'($urandom);
      if (en_i && $urandom_range(0, 59) == 0) en_i = 1'b0;
      else if (!en_i && $urandom_range(0, 2) == 0) en_i = 1'b1;
    end

    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
